// File: rtl/perf_ctrl_pkg.sv
// rtl/perf_ctrl_pkg.sv - shared CPU definitions: perf FSM states, counter width, LED display ops
//
// Purpose:
//   Holds the constants that the performance controller, the CPU glue and the
//   LED display block must agree on: FSM state encodings, the default
//   statistics counter width and the display-op codes used to select which
//   statistic is shown.
package perf_ctrl_pkg;

  // Default width of every statistics counter.
  localparam int unsigned CNT_WIDTH_DEFAULT = 32;

  // FSM state encodings. These are plain constants so that older display
  // logic can compare against them without depending on an enum type.
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN    = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSED = 2'd2;
  localparam logic [STATE_W-1:0] ST_HALTED = 2'd3;

  // Operation codes understood by the LED display block.
  typedef enum logic [2:0] {
    LED_OP_STATE  = 3'd0,
    LED_OP_TOTAL  = 3'd1,
    LED_OP_UNCOND = 3'd2,
    LED_OP_COND   = 3'd3,
    LED_OP_BUBBLE = 3'd4,
    LED_OP_BLANK  = 3'd7
  } led_op_e;

  // Retirement events reported by the pipeline in one cycle.
  typedef struct packed {
    logic uncond_br;
    logic cond_br_taken;
    logic bubble;
  } perf_events_t;

  // True when the pipeline is allowed to advance.
  function automatic logic is_running(input logic [STATE_W-1:0] st);
    return st == ST_RUN;
  endfunction

endpackage

// File: rtl/perf_ctrl_sat_counter.sv
// rtl/perf_ctrl_sat_counter.sv - saturating up-counter used for every statistic
//
// Purpose:
//   Counts clock edges on which inc is high. The count sticks at all-ones
//   rather than wrapping, so a long run never displays a small bogus value.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset, clears the count
//   inc    in   add one on this edge (ignored once saturated)
//   count  out  registered count value, WIDTH bits
module sat_counter
  import perf_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/perf_ctrl.sv
// rtl/perf_ctrl.sv - run/pause/halt controller and retirement statistics for the CPU
//
// Purpose:
//   Gates the CPU pipeline with cpu_enable according to a four-state FSM
//   (IDLE, RUN, PAUSED, HALTED) driven by the go switch and WB-stage
//   syscalls, and counts run cycles, unconditional jumps, taken conditional
//   branches and bubbles while running.
//
// Ports:
//   clk                 in   divided CPU clock, rising edge
//   rst                 in   asynchronous active-low reset
//   go                  in   run/resume level; only a fresh rising edge acts
//   halt_req            in   halt syscall retiring this cycle
//   pause_req           in   display/pause syscall retiring this cycle
//   uncond_br           in   unconditional jump retired this cycle
//   cond_br_taken       in   taken conditional branch retired this cycle
//   bubble              in   pipeline bubble inserted this cycle
//   cpu_enable          out  pipeline advance enable (state == RUN)
//   state               out  current FSM state for display
//   total_cycles        out  RUN cycle count
//   uncondi_branch_num  out  unconditional jump count
//   condi_branch_num    out  taken conditional branch count
//   bubble_num          out  bubble count
module perf_ctrl
  import perf_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 halt_req,
  input  logic                 pause_req,
  input  logic                 uncond_br,
  input  logic                 cond_br_taken,
  input  logic                 bubble,
  output logic                 cpu_enable,
  output logic [STATE_W-1:0]   state,
  output logic [CNT_WIDTH-1:0] total_cycles,
  output logic [CNT_WIDTH-1:0] uncondi_branch_num,
  output logic [CNT_WIDTH-1:0] condi_branch_num,
  output logic [CNT_WIDTH-1:0] bubble_num
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               go_q;
  logic               go_armed_q;
  logic               go_armed_d;
  logic               go_rise_q;
  logic               go_rise_d;
  logic               running;
  perf_events_t       events;

  // go edge detection. go_armed_q only sets once go has been seen low after
  // reset, so a switch left high across reset cannot start the CPU. The
  // detected edge is registered, which makes the FSM react one cycle after
  // go first samples high.
  assign go_armed_d = go_armed_q | ~go;
  assign go_rise_d  = go & ~go_q & go_armed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_q       <= 1'b0;
      go_armed_q <= 1'b0;
      go_rise_q  <= 1'b0;
    end else begin
      go_q       <= go;
      go_armed_q <= go_armed_d;
      go_rise_q  <= go_rise_d;
    end
  end

  // Halt beats pause when both retire together; HALTED only leaves on reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go_rise_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req)       state_d = ST_HALTED;
        else if (pause_req) state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (go_rise_q) state_d = ST_RUN;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign running    = is_running(state_q);
  assign cpu_enable = running;
  assign state      = state_q;

  // Events only count while running; the cycle that retires halt/pause is
  // still a RUN cycle and is counted.
  assign events.uncond_br     = running & uncond_br;
  assign events.cond_br_taken = running & cond_br_taken;
  assign events.bubble        = running & bubble;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_total_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (running),
    .count (total_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_uncond_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (events.uncond_br),
    .count (uncondi_branch_num)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cond_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (events.cond_br_taken),
    .count (condi_branch_num)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (events.bubble),
    .count (bubble_num)
  );

endmodule

// File: doc/perf_ctrl.md
PERF_CTRL -- requirements
Module: perf_ctrl

Interface
REQ-001 The block SHALL take parameter CNT_WIDTH, default 32, as the width of every statistics counter.
REQ-002 clk  input  1  single system clock, the same divided CPU clock that drives the CPU and RAM; all state is on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-004 go  input  1  run/resume level from the switch-conversion block; only its rising edge has effect.
REQ-005 halt_req  input  1  WB-stage halt syscall retiring this cycle.
REQ-006 pause_req  input  1  WB-stage display/pause syscall retiring this cycle.
REQ-007 uncond_br  input  1  unconditional jump retired this cycle.
REQ-008 cond_br_taken  input  1  taken conditional branch retired this cycle.
REQ-009 bubble  input  1  pipeline inserted a bubble (stall or flush) this cycle.
REQ-010 cpu_enable  output  1  pipeline advance enable to the CPU.
REQ-011 state  output  2  current FSM state for display.
REQ-012 total_cycles, uncondi_branch_num, condi_branch_num, bubble_num  output  CNT_WIDTH each  statistics to the LED display block.

Function
REQ-013 FSM states SHALL be IDLE=0, RUN=1, PAUSED=2, HALTED=3.
REQ-014 go_rise SHALL be go high while go registered one cycle earlier was low; go_rise is therefore seen one cycle after go first samples high.
REQ-015 IDLE -> RUN on go_rise; otherwise hold.
REQ-016 RUN -> HALTED on halt_req; else RUN -> PAUSED on pause_req; else hold. Halt has priority when both are asserted.
REQ-017 PAUSED -> RUN on go_rise; otherwise hold.
REQ-018 HALTED SHALL persist until reset; go_rise is ignored.
REQ-019 cpu_enable SHALL be 1 iff state==RUN, decoded directly from the state register with no extra latency.
REQ-020 Event inputs SHALL be ignored in every state except RUN.
REQ-021 total_cycles SHALL increment by 1 on every clock edge where state==RUN. This includes the cycle in which halt_req or pause_req is sampled.
REQ-022 uncondi_branch_num, condi_branch_num and bubble_num SHALL each increment by 1 on an edge where state==RUN and the matching input is 1.
REQ-023 Simultaneous events SHALL each update their own counter in the same cycle.
REQ-024 All counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-025 Counter outputs SHALL be register outputs, valid one cycle after the counted edge.
REQ-026 Counters SHALL hold their values in PAUSED and HALTED so the LED block can display them.

Reset
REQ-027 On rst low, asynchronously: state=IDLE, cpu_enable=0, all four counters=0, registered go=0.
REQ-028 Reset asserted mid-RUN SHALL abort counting immediately; no partial increment SHALL be visible.
REQ-029 After rst deasserts with go already high, no go_rise SHALL occur until go drops and rises again.

Structure
REQ-030 State encodings and the CNT_WIDTH default SHALL live in the shared CPU package/header, alongside the LED display-op codes.
REQ-031 A single sub-module sat_counter SHALL be instantiated four times. It is parameterised on width, with inputs clk, rst and inc, and a saturating count output.

Verification
REQ-032 Reset, go low for 5 cycles, then go high -> state IDLE, then RUN two edges after go rises; cpu_enable=1; total_cycles=0 at entry.
REQ-033 RUN for 10 cycles with uncond_br on 3 cycles, cond_br_taken on 2 and bubble on 4, then halt_req -> HALTED; total_cycles=11, 3/2/4; go toggles leave all values unchanged.
REQ-034 pause_req in RUN -> PAUSED, cpu_enable=0, counters frozen for 20 cycles; go rise -> RUN; counting resumes from the frozen values.
REQ-035 halt_req and pause_req in the same cycle -> HALTED.
REQ-036 CNT_WIDTH=4, 20 RUN cycles with bubble held high -> total_cycles and bubble_num stick at 15.
REQ-037 rst pulsed low mid-RUN between clock edges -> state IDLE and counters 0 immediately; with go held high, the block stays in IDLE until go is re-toggled.
